// File: rtl/scm_march_bist.sv
// March C- BIST controller for a single-port synchronous memory.
// Issues one operation per cycle and compares each read one cycle after it is driven.
module scm_march_bist #(
   parameter int ADDR_WIDTH = 5,
   parameter int DATA_WIDTH = 32,
   parameter int NUM_WORDS  = 2**ADDR_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  Start,
   output logic                  Busy,
   output logic                  Done,
   output logic                  Pass,
   output logic [7:0]            FailCount,
   output logic [ADDR_WIDTH-1:0] FailAddr,
   output logic                  BIST,
   output logic                  CSN_T,
   output logic                  WEN_T,
   output logic [ADDR_WIDTH-1:0] A_T,
   output logic [DATA_WIDTH-1:0] D_T,
   input  logic [DATA_WIDTH-1:0] Q_T
);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   localparam logic [ADDR_WIDTH-1:0] LAST_A = ADDR_WIDTH'(NUM_WORDS - 1);

   state_t                state_q, state_d;
   logic [2:0]            elem_q, elem_d;
   logic                  phase_q, phase_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic                  rd_vld_q, rd_vld_d;
   logic [7:0]            fail_cnt_q, fail_cnt_d;
   logic [ADDR_WIDTH-1:0] fail_addr_q, fail_addr_d;
   logic                  pass_q, pass_d;
   logic                  exp_q, exp_d;
   logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
   logic                  is_rd, mismatch;
   logic [2:0]            elem_nxt;

   // Elements 0..2 ascend, 3..5 descend; 1..4 are read-then-write pairs.
   function automatic logic is_desc(input logic [2:0] e);
      return e >= 3'd3;
   endfunction

   function automatic logic is_pair(input logic [2:0] e);
      return (e != 3'd0) && (e != 3'd5);
   endfunction

   function automatic logic rd_pat(input logic [2:0] e);
      return (e == 3'd2) || (e == 3'd4);
   endfunction

   function automatic logic wr_pat(input logic [2:0] e);
      return (e == 3'd1) || (e == 3'd3);
   endfunction

   function automatic logic [7:0] sat_inc(input logic [7:0] x);
      return (x == 8'hFF) ? x : x + 8'd1;
   endfunction

   always_comb begin
      state_d     = state_q;
      elem_d      = elem_q;
      phase_d     = phase_q;
      addr_d      = addr_q;
      fail_cnt_d  = fail_cnt_q;
      fail_addr_d = fail_addr_q;
      pass_d      = pass_q;
      rd_vld_d    = 1'b0;
      exp_d       = rd_pat(elem_q);
      rd_addr_d   = addr_q;
      CSN_T       = 1'b1;
      WEN_T       = 1'b1;
      A_T         = '0;
      D_T         = '0;
      elem_nxt    = elem_q + 3'd1;
      is_rd       = (elem_q == 3'd5) || (is_pair(elem_q) && !phase_q);
      mismatch    = rd_vld_q && (Q_T != {DATA_WIDTH{exp_q}});

      if (mismatch) begin
         if (fail_cnt_q == 8'd0) fail_addr_d = rd_addr_q;
         fail_cnt_d = sat_inc(fail_cnt_q);
      end

      case (state_q)
         IDLE: begin
            if (Start) begin
               state_d     = RUN;
               elem_d      = 3'd0;
               phase_d     = 1'b0;
               addr_d      = '0;
               fail_cnt_d  = 8'd0;
               fail_addr_d = '0;
               pass_d      = 1'b0;
            end
         end
         RUN: begin
            CSN_T    = 1'b0;
            WEN_T    = is_rd;
            A_T      = addr_q;
            D_T      = is_rd ? '0 : {DATA_WIDTH{wr_pat(elem_q)}};
            rd_vld_d = is_rd;
            if (!is_pair(elem_q) || phase_q) begin
               phase_d = 1'b0;
               if (addr_q == (is_desc(elem_q) ? '0 : LAST_A)) begin
                  if (elem_q == 3'd5) begin
                     state_d = DRAIN;
                  end else begin
                     elem_d = elem_nxt;
                     addr_d = is_desc(elem_nxt) ? LAST_A : '0;
                  end
               end else begin
                  addr_d = is_desc(elem_q) ? addr_q - 1'b1 : addr_q + 1'b1;
               end
            end else begin
               phase_d = 1'b1;
            end
         end
         DRAIN: begin
            // The last read's compare lands on this edge, so Pass uses the updated count.
            state_d = DONE;
            pass_d  = (fail_cnt_d == 8'd0);
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         elem_q      <= 3'd0;
         phase_q     <= 1'b0;
         addr_q      <= '0;
         rd_vld_q    <= 1'b0;
         fail_cnt_q  <= 8'd0;
         fail_addr_q <= '0;
         pass_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         elem_q      <= elem_d;
         phase_q     <= phase_d;
         addr_q      <= addr_d;
         rd_vld_q    <= rd_vld_d;
         fail_cnt_q  <= fail_cnt_d;
         fail_addr_q <= fail_addr_d;
         pass_q      <= pass_d;
      end
   end

   // Expected pattern and address travel with the read; qualified by rd_vld_q.
   always_ff @(posedge clk) begin
      exp_q     <= exp_d;
      rd_addr_q <= rd_addr_d;
   end

   assign Busy      = (state_q == RUN) || (state_q == DRAIN);
   assign BIST      = Busy;
   assign Done      = (state_q == DONE);
   assign Pass      = pass_q;
   assign FailCount = fail_cnt_q;
   assign FailAddr  = fail_addr_q;

endmodule
